// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the copy engine: bus defaults, FSM state
// encodings and the full byte-select constant.
package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    localparam logic [WB_DW/8-1:0] WB_SEL_ALL = '1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_RD_GAP = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_WR_GAP = 3'd4;

endpackage

// File: rtl/wb_copy_dma_if.sv
// Wishbone classic bus bundle between the copy engine (master) and a responder.
// The master raises cyc and stb together and holds adr/we/dat/sel stable until
// ack; an access completes on the edge where stb and ack are both high, and
// a cycle with stb low separates consecutive accesses.
interface wb_copy_dma_if import wb_pkg::*; #(
    parameter int AW = WB_AW,
    parameter int DW = WB_DW
);

    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_we_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/wb_ack_timeout.sv
// Per-access watchdog: counts cycles without ack and flags when the wait
// budget of TIMEOUT cycles is used up.
module wb_ack_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    // expired is high during the TIMEOUT-th unacknowledged cycle
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (!ack && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/wb_copy_dma.sv
// Wishbone block-copy initiator: one read then one write per word, with a
// mandatory idle cycle between accesses and a per-access ack timeout.
module wb_copy_dma import wb_pkg::*; #(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_reset_i,
    input  logic             start_i,
    input  logic [AW-1:0]    src_i,
    input  logic [AW-1:0]    dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       state_o,
    wb_copy_dma_if.master    wb
);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    buf_q, buf_d;
    logic [DW/8-1:0]  sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic             in_access;
    logic             tmo_clear;
    logic             expired;

    assign in_access = (state_q == ST_RD) || (state_q == ST_WR);
    assign tmo_clear = !in_access;

    wb_ack_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_reset_i),
        .clear   (tmo_clear),
        .ack     (wb.wb_ack_i),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            adr_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i && (len_i != '0)) state_d = ST_RD;
            ST_RD: begin
                if (wb.wb_ack_i)   state_d = ST_RD_GAP;
                else if (expired)  state_d = ST_IDLE;
            end
            ST_RD_GAP: state_d = ST_WR;
            ST_WR: begin
                if (wb.wb_ack_i)   state_d = ST_WR_GAP;
                else if (expired)  state_d = ST_IDLE;
            end
            ST_WR_GAP: state_d = (cnt_q == '0) ? ST_IDLE : ST_RD;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes from a flop.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        buf_d  = buf_q;
        err_d  = err_q;
        done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d = src_i;
                        dst_d = dst_i;
                        cnt_d = len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (wb.wb_ack_i) begin
                    buf_d = wb.wb_dat_i;
                end else if (expired) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            ST_WR: begin
                if (wb.wb_ack_i) begin
                    src_d = src_q + AW'(1);
                    dst_d = dst_q + AW'(1);
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (expired) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            ST_WR_GAP: begin
                if (cnt_q == '0) done_d = 1'b1;
            end
            default: ;
        endcase

        cyc_d  = (state_d == ST_RD) || (state_d == ST_WR);
        we_d   = (state_d == ST_WR);
        busy_d = (state_d != ST_IDLE);
        sel_d  = cyc_d ? {(DW/8){1'b1}} : '0;
        if (state_d == ST_RD)      adr_d = src_d;
        else if (state_d == ST_WR) adr_d = dst_d;
        else                       adr_d = '0;
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign state_o     = state_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = buf_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_copy_dma.sv
// Scoreboard bench for wb_copy_dma: an SRAM-like responder, directed copies,
// expected bus accesses and done pulses queued by the driver, checked by a monitor.
module tb_wb_copy_dma;
    import wb_pkg::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    src;
    logic [AW-1:0]    dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       state;

    wb_copy_dma_if #(.AW(AW), .DW(DW)) wb();

    wb_copy_dma #(
        .AW(AW), .DW(DW), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .wb_clk_i   (clk),
        .wb_reset_i (rst),
        .start_i    (start),
        .src_i      (src),
        .dst_i      (dst),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .state_o    (state),
        .wb         (wb)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- responder (256-word memory) ----------------
    logic        comb_mode = 1'b0;
    logic        stall_en  = 1'b0;
    logic [31:0] stall_adr = '0;
    logic        preload   = 1'b0;
    logic [31:0] mem [256];
    logic        ack_q;
    logic [31:0] rdata_q;
    logic        stall_now;

    function automatic logic [31:0] pat(input int a);
        if (a >= 16 && a < 20) return 32'h0000_00A0 + 32'(a - 16);
        return 32'hCAFE_0000 | 32'(a);
    endfunction

    assign stall_now = stall_en && !wb.wb_we_o && (wb.wb_adr_o == stall_adr);

    always_comb begin
        if (comb_mode) begin
            wb.wb_ack_i = wb.wb_cyc_o && wb.wb_stb_o && !stall_now;
            wb.wb_dat_i = mem[wb.wb_adr_o[7:0]];
        end else begin
            wb.wb_ack_i = ack_q;
            wb.wb_dat_i = rdata_q;
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= !comb_mode && wb.wb_cyc_o && wb.wb_stb_o && !ack_q && !stall_now;
            if (wb.wb_cyc_o && wb.wb_stb_o && !stall_now && (comb_mode || !ack_q)) begin
                if (wb.wb_we_o) mem[wb.wb_adr_o[7:0]] <= wb.wb_dat_o;
                else            rdata_q <= mem[wb.wb_adr_o[7:0]];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [64:0] exp_q[$];        // {we, adr, wdata}
    logic [32:0] exp_done_q[$];   // {err, cycle}
    logic [64:0] bus_e;
    logic [32:0] done_e;
    logic        prev_acc = 1'b0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb.wb_cyc_o && wb.wb_stb_o && !prev_acc) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got access we=%0b adr=%0h, required none",
                         wb.wb_we_o, wb.wb_adr_o);
            end else begin
                bus_e = exp_q.pop_front();
                check("bus_we_adr", 65'({wb.wb_we_o, wb.wb_adr_o}), 65'(bus_e[64:32]));
                if (bus_e[64]) check("bus_wdat", 65'(wb.wb_dat_o), 65'(bus_e[31:0]));
                check("bus_sel", 65'(wb.wb_sel_o), 65'(WB_SEL_ALL));
            end
        end
        prev_acc <= wb.wb_cyc_o && wb.wb_stb_o;
        if (done) begin
            done_cnt++;
            if (exp_done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done_o=1 at cycle %0d, required none", cyc_cnt);
            end else begin
                done_e = exp_done_q.pop_front();
                check("done_cycle", 65'(cyc_cnt), 65'(done_e[31:0]));
                check("done_err", 65'(err), 65'(done_e[32]));
                check("done_bus_idle", 65'({busy, wb.wb_cyc_o, wb.wb_stb_o}), 65'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                             input logic stall, input logic [31:0] s_adr);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({1'b0, s + 32'(w), 32'h0});
            if (stall && (s + 32'(w) == s_adr)) break;
            exp_q.push_back({1'b1, d + 32'(w), pat(int'((s + 32'(w)) & 32'hFF))});
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int lat, input logic exp_err, input logic want_done,
                            output int unsigned t);
        @(negedge clk);
        t = cyc_cnt;
        if (want_done) exp_done_q.push_back({exp_err, 32'(t + lat)});
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 65'(busy), 65'(l != 0));
        check("start_stb", 65'(wb.wb_stb_o), 65'(l != 0));
        check("start_err_clear", 65'(err), 65'(0));
    endtask

    task automatic wait_done(input int budget);
        int n0;
        logic seen;
        n0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != n0) seen = 1'b1;
        end
        check("done_within_budget", 65'(seen), 65'(1));
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, 65'({busy, done, err, state, wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o}), 65'(0));
        check({name, "_adr_dat"}, {1'b0, wb.wb_adr_o, wb.wb_dat_o}, 65'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int unsigned t;
        int a0;
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst = 1'b0;

        // 4-word copy with registered ack: 6 cycles per word
        a0 = acc_cnt;
        push_copy(32'h10, 32'h80, 4, 1'b0, '0);
        do_start(32'h10, 32'h80, 4, 25, 1'b0, 1'b1, t);
        wait_done(60);
        check("copy4_m80", 65'(mem[8'h80]), 65'h0A0);
        check("copy4_m81", 65'(mem[8'h81]), 65'h0A1);
        check("copy4_m82", 65'(mem[8'h82]), 65'h0A2);
        check("copy4_m83", 65'(mem[8'h83]), 65'h0A3);
        check("copy4_access_count", 65'(acc_cnt - a0), 65'(8));

        // zero length: done next cycle, no bus activity
        a0 = acc_cnt;
        do_start(32'h30, 32'h70, 0, 1, 1'b0, 1'b1, t);
        wait_done(10);
        @(negedge clk);
        check("len0_busy", 65'(busy), 65'(0));
        check("len0_no_access", 65'(acc_cnt - a0), 65'(0));

        // second read never acked: first word kept, timeout after 8 waits
        stall_en  = 1'b1;
        stall_adr = 32'h21;
        push_copy(32'h20, 32'h90, 3, 1'b1, 32'h21);
        do_start(32'h20, 32'h90, 3, 15, 1'b1, 1'b1, t);
        wait_done(40);
        stall_en = 1'b0;
        @(negedge clk);
        check("tmo_err_sticky", 65'(err), 65'(1));
        check("tmo_m90", 65'(mem[8'h90]), 65'hCAFE_0020);
        check("tmo_m91", 65'(mem[8'h91]), 65'hCAFE_0091);

        // source wraps past the top of the address space; also clears err
        push_copy(32'hFFFF_FFFE, 32'h60, 4, 1'b0, '0);
        do_start(32'hFFFF_FFFE, 32'h60, 4, 25, 1'b0, 1'b1, t);
        wait_done(60);
        check("wrap_m60", 65'(mem[8'h60]), 65'hCAFE_00FE);
        check("wrap_m61", 65'(mem[8'h61]), 65'hCAFE_00FF);
        check("wrap_m62", 65'(mem[8'h62]), 65'hCAFE_0000);
        check("wrap_m63", 65'(mem[8'h63]), 65'hCAFE_0001);

        // start re-pulsed while busy must be ignored
        push_copy(32'h10, 32'hB0, 3, 1'b0, '0);
        do_start(32'h10, 32'hB0, 3, 19, 1'b0, 1'b1, t);
        repeat (2) @(negedge clk);
        start = 1'b1; src = 32'h50; dst = 32'hC0; len = 7;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        check("restart_mB0", 65'(mem[8'hB0]), 65'h0A0);
        check("restart_mB2", 65'(mem[8'hB2]), 65'h0A2);
        check("restart_mC0", 65'(mem[8'hC0]), 65'hCAFE_00C0);

        // same-cycle ack: 4 cycles per word
        comb_mode = 1'b1;
        push_copy(32'h12, 32'hD0, 2, 1'b0, '0);
        do_start(32'h12, 32'hD0, 2, 9, 1'b0, 1'b1, t);
        wait_done(30);
        comb_mode = 1'b0;
        check("comb_mD0", 65'(mem[8'hD0]), 65'h0A2);
        check("comb_mD1", 65'(mem[8'hD1]), 65'h0A3);

        // reset during the write of word 2 of 5: abort with no done
        push_copy(32'h40, 32'hA0, 2, 1'b0, '0);
        do_start(32'h40, 32'hA0, 5, 0, 1'b0, 1'b0, t);
        while (cyc_cnt < t + 10) @(negedge clk);
        check("rst_point_wr2", 65'({wb.wb_we_o, wb.wb_stb_o, wb.wb_adr_o}), 65'({2'b11, 32'hA1}));
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midcopy_reset_outputs");
        rst = 1'b0;
        repeat (30) @(negedge clk);

        // normal copy after the abort
        push_copy(32'h10, 32'hE0, 4, 1'b0, '0);
        do_start(32'h10, 32'hE0, 4, 25, 1'b0, 1'b1, t);
        wait_done(60);
        check("after_rst_mE0", 65'(mem[8'hE0]), 65'h0A0);
        check("after_rst_mE3", 65'(mem[8'hE3]), 65'h0A3);

        repeat (3) @(negedge clk);
        check("bus_queue_drained", 65'(exp_q.size()), 65'(0));
        check("done_queue_drained", 65'(exp_done_q.size()), 65'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
